// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID->EX pipeline register with stall, flush, load-use bubble and optional WB bypass.
// Latency: 1 cycle input->output; hazard_o is the only combinational output.
// Backpressure: stall_i holds every output; hazard_o asks upstream to hold PC and IF/ID.
//
// Ports:
//   clk_i, rst_i (async, active-high)             clock and reset
//   valid_i, stall_i, flush_i                     slot valid, hold, kill
//   pc_i, rs/rt/rd_addr_i, rs/rt_data_i, imm_i    decoded ID instruction
//   ctrl_i [CTRL_W]                               decoded control, all-zero = NOP
//   wb_we_i, wb_addr_i, wb_data_i                 WB-stage register write port
//   hazard_o                                      load-use hazard (combinational)
//   valid_o, pc_o ... ctrl_o                      registered EX copies of the inputs
//
// Build option: define WB_BYPASS_EN to bypass same-cycle WB writes into rs/rt data.
`timescale 1ns/1ps

module id_ex_stage_reg #(
  parameter int CTRL_W      = 12,
  parameter int MEMREAD_BIT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [31:0]       pc_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [31:0]       rs_data_i,
  input  logic [31:0]       rt_data_i,
  input  logic [31:0]       imm_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [31:0]       wb_data_i,
  output logic              hazard_o,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic [31:0]       rs_data_o,
  output logic [31:0]       rt_data_o,
  output logic [31:0]       imm_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic        load_use;
  logic [31:0] rs_load;
  logic [31:0] rt_load;
  logic [31:0] rs_hold;
  logic [31:0] rt_hold;

  // A load in EX whose destination is read by the instruction in ID.
  // Register 0 is hard-wired to zero, so it can never create a dependency.
  assign load_use = valid_o & ctrl_o[MEMREAD_BIT] & valid_i & (rd_addr_o != 5'd0) &
                    ((rd_addr_o == rs_addr_i) | (rd_addr_o == rt_addr_i));
  assign hazard_o = load_use;

`ifdef WB_BYPASS_EN
  // Register file reads happen before the WB write lands, so a same-cycle
  // write to a source register is taken from the WB port instead.
  assign rs_load = (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs_addr_i)) ? wb_data_i : rs_data_i;
  assign rt_load = (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == rt_addr_i)) ? wb_data_i : rt_data_i;
  // While held, keep snooping WB against the held indices so the operands
  // EX eventually consumes reflect writes that retired during the stall.
  assign rs_hold = (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs_addr_o)) ? wb_data_i : rs_data_o;
  assign rt_hold = (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == rt_addr_o)) ? wb_data_i : rt_data_o;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we_i, wb_addr_i, wb_data_i};
  assign rs_load   = rs_data_i;
  assign rt_load   = rt_data_i;
  assign rs_hold   = rs_data_o;
  assign rt_hold   = rt_data_o;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      pc_o      <= '0;
      rs_addr_o <= '0;
      rt_addr_o <= '0;
      rd_addr_o <= '0;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      ctrl_o    <= '0;
    end else begin
      // Payload fields advance on flush and bubble as well: the slot is
      // marked invalid, so their contents are irrelevant there.
      if (flush_i || !stall_i) begin
        pc_o      <= pc_i;
        rs_addr_o <= rs_addr_i;
        rt_addr_o <= rt_addr_i;
        rd_addr_o <= rd_addr_i;
        rs_data_o <= rs_load;
        rt_data_o <= rt_load;
        imm_o     <= imm_i;
      end else begin
        rs_data_o <= rs_hold;
        rt_data_o <= rt_hold;
      end

      // Flush beats stall; stall beats the bubble so a held load stays in EX.
      if (flush_i || (!stall_i && load_use)) begin
        valid_o <= 1'b0;
        ctrl_o  <= '0;
      end else if (!stall_i) begin
        valid_o <= valid_i;
        ctrl_o  <= valid_i ? ctrl_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
`timescale 1ns/1ps

module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] pc = '0, rs_data = '0, rt_data = '0, imm = '0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic [11:0] ctrl = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  logic        hazard_q, valid_q;
  logic [31:0] pc_q, rs_data_q, rt_data_q, imm_q;
  logic [4:0]  rs_addr_q, rt_addr_q, rd_addr_q;
  logic [11:0] ctrl_q;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] LW_CTRL  = 12'h008;  // MemRead set
  localparam logic [11:0] ADD_CTRL = 12'h401;

  id_ex_stage_reg #(.CTRL_W(12), .MEMREAD_BIT(3)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
    .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm), .ctrl_i(ctrl),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .hazard_o(hazard_q), .valid_o(valid_q), .pc_o(pc_q),
    .rs_addr_o(rs_addr_q), .rt_addr_o(rt_addr_q), .rd_addr_o(rd_addr_q),
    .rs_data_o(rs_data_q), .rt_data_o(rt_data_q), .imm_o(imm_q), .ctrl_o(ctrl_q)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction sitting in EX, as a record.
  typedef struct {
    bit          valid;
    logic [11:0] ctrl;
    logic [31:0] pc, rs_d, rt_d, imm;
    logic [4:0]  rs_a, rt_a, rd_a;
  } slot_t;

  slot_t ex;

  function automatic logic [31:0] wb_view(logic [4:0] a, logic [31:0] d);
`ifdef WB_BYPASS_EN
    if (wb_we && a != 0 && wb_addr == a) return wb_data;
`endif
    return d;
  endfunction

  function automatic bit exp_hazard();
    bit ex_is_load = ex.valid && ex.ctrl[3];
    bit reads_dest = (ex.rd_a == rs_addr) || (ex.rd_a == rt_addr);
    return ex_is_load && valid && ex.rd_a != 0 && reads_dest;
  endfunction

  task automatic model_reset();
    ex = '{valid: 0, ctrl: '0, pc: '0, rs_d: '0, rt_d: '0, imm: '0,
           rs_a: '0, rt_a: '0, rd_a: '0};
  endtask

  // What the rising edge does to the EX slot.
  task automatic model_edge();
    bit haz = exp_hazard();
    if (rst) begin
      model_reset();
    end else if (flush) begin
      ex.valid = 0;
      ex.ctrl  = '0;
    end else if (stall) begin
      ex.rs_d = wb_view(ex.rs_a, ex.rs_d);
      ex.rt_d = wb_view(ex.rt_a, ex.rt_d);
    end else if (haz) begin
      ex.valid = 0;
      ex.ctrl  = '0;
    end else begin
      ex.valid = valid;
      ex.ctrl  = valid ? ctrl : 12'h000;
      ex.pc    = pc;
      ex.rs_a  = rs_addr;
      ex.rt_a  = rt_addr;
      ex.rd_a  = rd_addr;
      ex.rs_d  = wb_view(rs_addr, rs_data);
      ex.rt_d  = wb_view(rt_addr, rt_data);
      ex.imm   = imm;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_o", {31'd0, valid_q}, {31'd0, ex.valid});
    chk("ctrl_o", {20'd0, ctrl_q}, {20'd0, ex.ctrl});
    chk("hazard_o", {31'd0, hazard_q}, {31'd0, exp_hazard()});
    if (ex.valid) begin
      chk("pc_o", pc_q, ex.pc);
      chk("rs_addr_o", {27'd0, rs_addr_q}, {27'd0, ex.rs_a});
      chk("rt_addr_o", {27'd0, rt_addr_q}, {27'd0, ex.rt_a});
      chk("rd_addr_o", {27'd0, rd_addr_q}, {27'd0, ex.rd_a});
      chk("rs_data_o", rs_data_q, ex.rs_d);
      chk("rt_data_o", rt_data_q, ex.rt_d);
      chk("imm_o", imm_q, ex.imm);
    end
  endtask

  // Inputs are set just after a falling edge; check, then take the rising edge.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [11:0] c, input logic [4:0] s,
                           input logic [4:0] t, input logic [4:0] d, input logic [31:0] p);
    valid = v; ctrl = c; rs_addr = s; rt_addr = t; rd_addr = d; pc = p;
    rs_data = 32'h1000 + {27'd0, s}; rt_data = 32'h2000 + {27'd0, t}; imm = 32'h4;
  endtask

  initial begin
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_all();
    chk("rst_valid", {31'd0, valid_q}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain LOAD
    set_instr(1, ADD_CTRL, 5'd1, 5'd2, 5'd3, 32'h100);
    rs_data = 32'h11; imm = 32'hFFFF_FFF0;
    cycle();
    #1;
    chk("load_rs", rs_data_q, 32'h11);
    chk("load_imm", imm_q, 32'hFFFF_FFF0);
    chk("load_valid", {31'd0, valid_q}, 32'd1);

    // Load-use: lw r8, then add using r8
    set_instr(1, LW_CTRL, 5'd1, 5'd2, 5'd8, 32'h104);
    cycle();
    set_instr(1, ADD_CTRL, 5'd8, 5'd3, 5'd9, 32'h108);
    #1 chk("lu_hazard", {31'd0, hazard_q}, 32'd1);
    cycle();
    #1;
    chk("lu_bubble_valid", {31'd0, valid_q}, 32'd0);
    chk("lu_bubble_ctrl", {20'd0, ctrl_q}, 32'd0);
    chk("lu_hazard_drop", {31'd0, hazard_q}, 32'd0);
    cycle();
    #1;
    chk("lu_add_rd", {27'd0, rd_addr_q}, 32'd9);
    chk("lu_add_ctrl", {20'd0, ctrl_q}, {20'd0, ADD_CTRL});

    // Back-to-back dependent loads: one bubble each
    set_instr(1, LW_CTRL, 5'd1, 5'd2, 5'd10, 32'h200); cycle();
    set_instr(1, LW_CTRL, 5'd10, 5'd0, 5'd11, 32'h204); cycle(); cycle(); cycle();
    set_instr(1, ADD_CTRL, 5'd4, 5'd11, 5'd12, 32'h208); cycle(); cycle(); cycle();
    chk("b2b_pc", pc_q, 32'h208);

    // Stall 3 cycles with changing inputs, then flush during stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, ADD_CTRL, 5'd5, 5'd6, 5'd7, 32'h300 + 32'(i));
      cycle();
      chk("stall_pc", pc_q, 32'h208);
    end
    flush = 1'b1;
    cycle();
    #1 chk("flush_valid", {31'd0, valid_q}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // WB bypass onto rt
    set_instr(1, ADD_CTRL, 5'd1, 5'd5, 5'd6, 32'h400);
    rt_data = 32'hDEAD; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFE;
    cycle();
`ifdef WB_BYPASS_EN
    chk("byp_rt", rt_data_q, 32'hCAFE);
`else
    chk("byp_rt", rt_data_q, 32'hDEAD);
`endif
    set_instr(1, ADD_CTRL, 5'd1, 5'd0, 5'd6, 32'h404);
    rt_data = 32'hDEAD; wb_addr = 5'd0;
    cycle();
    chk("byp_r0", rt_data_q, 32'hDEAD);
    wb_we = 1'b0;

    // Load with rd=0 in EX never causes a hazard
    set_instr(1, LW_CTRL, 5'd1, 5'd2, 5'd0, 32'h500); cycle();
    set_instr(1, ADD_CTRL, 5'd0, 5'd0, 5'd3, 32'h504);
    #1 chk("r0_no_hazard", {31'd0, hazard_q}, 32'd0);
    cycle();

    // Mid-cycle reset with a load pending a hazard
    set_instr(1, LW_CTRL, 5'd1, 5'd2, 5'd8, 32'h600); cycle();
    set_instr(1, ADD_CTRL, 5'd8, 5'd2, 5'd9, 32'h604);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, valid_q}, 32'd0);
    chk("rst_mid_pc", pc_q, 32'd0);
    chk("rst_mid_ctrl", {20'd0, ctrl_q}, 32'd0);
    chk("rst_mid_hazard", {31'd0, hazard_q}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      valid   = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      ctrl    = 12'($urandom) & ~LW_CTRL | (($urandom_range(0, 1) != 0) ? LW_CTRL : 12'h000);
      rs_addr = 5'($urandom_range(0, 3));
      rt_addr = 5'($urandom_range(0, 3));
      rd_addr = 5'($urandom_range(0, 3));
      pc      = $urandom; rs_data = $urandom; rt_data = $urandom; imm = $urandom;
      wb_we   = ($urandom_range(0, 1) != 0);
      wb_addr = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      cycle();
    end
    #1 check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
